// File: rtl/draw_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : draw_sched_pkg
// Brief    : Shared state encoding and widths for the triangle draw scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package draw_sched_pkg;

    localparam logic [1:0] C_ST_IDLE      = 2'd0;
    localparam logic [1:0] C_ST_WAIT_BUSY = 2'd1;
    localparam logic [1:0] C_ST_WAIT_DONE = 2'd2;

    localparam int C_ADDR_W = 16;

    // Queue occupancy needs one bit more than the pointer index to represent "full".
    function automatic int qcnt_w(input int qdepth);
        return $clog2(qdepth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/draw_sched_fifo.sv
`default_nettype none
// ============================================================================
// Module   : draw_sched_fifo
// Brief    : Register FIFO with wrap-around pointers, push/pop/flush and count.
// Revision : 1.0 - initial release
// ============================================================================
module draw_sched_fifo
    import draw_sched_pkg::*;
#(
    parameter int QDEPTH = 8,
    parameter int DW     = C_ADDR_W
) (
    input  logic                      CLK,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  logic [DW-1:0]             din,
    output logic [DW-1:0]             dout,
    output logic                      full,
    output logic                      empty,
    output logic [qcnt_w(QDEPTH)-1:0] count
);

    localparam int              C_AW   = $clog2(QDEPTH);
    localparam int              C_CW   = qcnt_w(QDEPTH);
    localparam logic [C_CW-1:0] C_FULL = C_CW'(QDEPTH);

    logic [DW-1:0]   r_mem [QDEPTH];
    logic [C_CW-1:0] r_wr_ptr;
    logic [C_CW-1:0] r_rd_ptr;
    logic            w_do_push;
    logic            w_do_pop;

    assign count     = r_wr_ptr - r_rd_ptr;
    assign full      = (count == C_FULL);
    assign empty     = (count == '0);
    assign dout      = r_mem[r_rd_ptr[C_AW-1:0]];
    assign w_do_push = push && !full && !flush;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + C_CW'(1);
            // Flush catches the read pointer up to the write pointer.
            if (flush)
                r_rd_ptr <= r_wr_ptr;
            else if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + C_CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_do_push)
            r_mem[r_wr_ptr[C_AW-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/draw_tri_sched.sv
`default_nettype none
// ============================================================================
// Module   : draw_tri_sched
// Brief    : Queues draw commands and issues them one at a time to the
//            triangle draw engine, tracking completions and errors.
// Options  : DRAW_SCHED_WDT_EN enables the busy/done watchdog (TIMEOUT).
// Revision : 1.0 - initial release
// ============================================================================
module draw_tri_sched
    import draw_sched_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int QDEPTH  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                      CLK,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    input  logic [C_ADDR_W-1:0]       cmd_edge_addr,
    output logic                      cmd_ready,
    input  logic                      flush,
    input  logic                      draw_busy,
    output logic                      draw_req_pulse,
    output logic [C_ADDR_W-1:0]       draw_edge_addr,
    output logic [qcnt_w(QDEPTH)-1:0] q_count,
    output logic                      sched_idle,
    output logic                      done_pulse,
    output logic [15:0]               done_count,
    output logic                      err_range,
    output logic                      err_timeout
);

    localparam logic [C_ADDR_W:0] C_DEPTH = (C_ADDR_W+1)'(DEPTH);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_req;
    logic [C_ADDR_W-1:0] r_addr;
    logic                r_done;
    logic [15:0]         r_done_cnt;
    logic                r_err_range;

    logic                w_full;
    logic                w_empty;
    logic [C_ADDR_W-1:0] w_fifo_dout;
    logic                w_accept;
    logic                w_in_range;
    logic                w_push;
    logic                w_reject;
    logic                w_pop;
    logic                w_done;
    logic                w_wdt_fire;
    logic                w_timeout;

    assign cmd_ready  = !w_full && !flush;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_in_range = ({1'b0, cmd_edge_addr} < C_DEPTH);
    assign w_push     = w_accept && w_in_range;
    assign w_reject   = w_accept && !w_in_range;

    draw_sched_fifo #(
        .QDEPTH (QDEPTH),
        .DW     (C_ADDR_W)
    ) u_fifo (
        .CLK   (CLK),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .flush (flush),
        .din   (cmd_edge_addr),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (q_count)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)
            r_state <= C_ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (!w_empty && !draw_busy)
                    w_state_nxt = C_ST_WAIT_BUSY;
            end
            C_ST_WAIT_BUSY: begin
                if (w_wdt_fire)
                    w_state_nxt = C_ST_IDLE;
                else if (draw_busy)
                    w_state_nxt = C_ST_WAIT_DONE;
            end
            C_ST_WAIT_DONE: begin
                if (!draw_busy || w_wdt_fire)
                    w_state_nxt = C_ST_IDLE;
            end
            default: w_state_nxt = C_ST_IDLE;
        endcase
    end

    // A genuine completion on the watchdog's last cycle wins over the timeout.
    always_comb begin
        w_pop     = (r_state == C_ST_IDLE) && !w_empty && !draw_busy;
        w_done    = (r_state == C_ST_WAIT_DONE) && !draw_busy;
        w_timeout = w_wdt_fire && !w_done;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_req       <= 1'b0;
            r_addr      <= '0;
            r_done      <= 1'b0;
            r_done_cnt  <= '0;
            r_err_range <= 1'b0;
        end else begin
            r_req  <= w_pop;
            r_done <= w_done;
            if (w_pop)
                r_addr <= w_fifo_dout;
            if (w_done)
                r_done_cnt <= r_done_cnt + 16'd1;
            if (w_reject)
                r_err_range <= 1'b1;
        end
    end

`ifdef DRAW_SCHED_WDT_EN
    localparam int                C_WDT_W    = ($clog2(TIMEOUT+1) > 8) ? $clog2(TIMEOUT+1) : 8;
    localparam logic [C_WDT_W-1:0] C_WDT_LAST = C_WDT_W'(TIMEOUT - 1);

    logic [C_WDT_W-1:0] r_wdt;
    logic               r_err_timeout;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_wdt         <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_pop)
                r_wdt <= '0;
            else if (r_state != C_ST_IDLE)
                r_wdt <= r_wdt + C_WDT_W'(1);
            if (w_timeout)
                r_err_timeout <= 1'b1;
        end
    end

    assign w_wdt_fire  = (r_state != C_ST_IDLE) && (r_wdt == C_WDT_LAST);
    assign err_timeout = r_err_timeout;
`else
    assign w_wdt_fire  = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign draw_req_pulse = r_req;
    assign draw_edge_addr = r_addr;
    assign done_pulse     = r_done;
    assign done_count     = r_done_cnt;
    assign err_range      = r_err_range;
    assign sched_idle     = (r_state == C_ST_IDLE) && w_empty;

endmodule
`default_nettype wire
